// File: rtl/simon_seg_pkg.sv
// rtl/simon_seg_pkg.sv - FSM states, segment glyphs and hex decode for the Simon 7-segment mux
package simon_seg_pkg;

    typedef enum logic [1:0] {DIG1, DEAD1, DIG2, DEAD2} seg_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/simon_seg_decoder.sv
// rtl/simon_seg_decoder.sv - combinational hex digit to 7-segment glyph
module simon_seg_decoder
    import simon_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    assign glyph = seg_decode(digit);

endmodule

// File: rtl/simon_seg_mux.sv
// rtl/simon_seg_mux.sv - two-digit 7-segment mux with dead time and frame-synchronous updates; optional SIMON_SEG_BLINK_EN
module simon_seg_mux
    import simon_seg_pkg::*;
#(
    parameter int REFRESH_DIV   = 1024,
    parameter int DEAD_CYCLES   = 4,
    parameter int BLANK_LEADING = 1,
    parameter int BLINK_FRAMES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic       seginv,
    input  logic       blink,
    output logic [6:0] seg,
    output logic       dig1,
    output logic       dig2,
    output logic       pending,
    output logic       frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    seg_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          slot_end, boundary, commit, blink_off;
    logic [7:0]    displayed, pend_reg;
    logic [3:0]    tens, digit_sel;
    logic [6:0]    glyph, seg_nxt, seg_r;
    logic          dig1_nxt, dig2_nxt, dig1_r, dig2_r;

    assign tens      = displayed[7:4];
    assign slot_end  = (state == DIG1 || state == DIG2) ? (cnt == REF_LAST) : (cnt == DEAD_LAST);
    assign boundary  = slot_end && (state == DEAD2 || (DEAD_CYCLES == 0 && state == DIG2));
    // With the display disabled every cycle acts as a boundary: nothing is lit, so no tearing.
    assign commit    = pending && (!ena || boundary);
    assign digit_sel = (state == DIG1) ? tens : displayed[3:0];

    simon_seg_decoder u_decoder (
        .digit (digit_sel),
        .glyph (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIG1;
            cnt   <= '0;
        end else if (!ena) begin
            state <= DIG1;
            cnt   <= '0;
        end else if (slot_end) begin
            state <= state_nxt;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIG1:    state_nxt = (DEAD_CYCLES == 0) ? DIG2 : DEAD1;
            DEAD1:   state_nxt = DIG2;
            DIG2:    state_nxt = (DEAD_CYCLES == 0) ? DIG1 : DEAD2;
            default: state_nxt = DIG1;
        endcase
    end

    always_comb begin
        seg_nxt  = SEG_BLANK;
        dig1_nxt = 1'b0;
        dig2_nxt = 1'b0;
        if (ena && !blink_off) begin
            case (state)
                DIG1: begin
                    if (!(BLANK_LEADING != 0 && tens == 4'h0)) begin
                        seg_nxt  = glyph;
                        dig1_nxt = 1'b1;
                    end
                end
                DIG2: begin
                    seg_nxt  = glyph;
                    dig2_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r      <= SEG_BLANK;
            dig1_r     <= 1'b0;
            dig2_r     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg_r      <= seg_nxt;
            dig1_r     <= dig1_nxt;
            dig2_r     <= dig2_nxt;
            frame_done <= ena && boundary;
        end
    end

    // The boundary commits the pre-cycle pend_reg; a coincident load stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            displayed <= 8'h00;
            pend_reg  <= 8'h00;
            pending   <= 1'b0;
        end else begin
            if (commit)
                displayed <= pend_reg;
            if (load)
                pend_reg <= bcd_in;
            pending <= load || (pending && !commit);
        end
    end

`ifdef SIMON_SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !blink) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else if (ena && boundary) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_off <= !blink_off;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = blink;
    assign blink_off    = 1'b0;
`endif

    assign seg  = seg_r ^ {7{seginv}};
    assign dig1 = dig1_r ^ seginv;
    assign dig2 = dig2_r ^ seginv;

endmodule
